// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the Read stage: per-GPR pending-write counters, issue grant/stall, flush drain.
// Optional build macro SCOREBOARD_WB_BYPASS_EN lets a source retiring its last pending write this cycle read as free.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_req,
  input  logic [IDX_W-1:0]    src1_idx,
  input  logic                src1_valid,
  input  logic [IDX_W-1:0]    src2_idx,
  input  logic                src2_valid,
  input  logic [IDX_W-1:0]    dst_idx,
  input  logic                dst_valid,
  input  logic                dst_special_valid,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  input  logic                wb_special_valid,
  input  logic                flush,
  output logic                issue_grant,
  output logic                stall_out,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                draining,
  output logic                err_underflow
);

  localparam int RAX_IDX = 0;
  localparam int RDX_IDX = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic              err_q;

  logic [NUM_REGS-1:0] wr_mask;
  logic [NUM_REGS-1:0] ret_mask;
  logic [NUM_REGS-1:0] raw_busy;
  logic [NUM_REGS-1:0] sat_vec;
  logic [NUM_REGS-1:0] udf_vec;
  logic                raw_hazard;
  logic                sat_hazard;
  logic                all_idle;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic inc;
      logic dec;

      // RDX:RAX pair writes/retires both halves together
      assign wr_mask[gi]  = (dst_valid && (dst_idx == IDX_W'(gi))) ||
                            (dst_special_valid && (gi == RAX_IDX || gi == RDX_IDX));
      assign ret_mask[gi] = (wb_valid && (wb_idx == IDX_W'(gi))) ||
                            (wb_special_valid && (gi == RAX_IDX || gi == RDX_IDX));

      assign busy_vec[gi] = (cnt_q[gi] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      // Register file writes before it reads, so the final retiring write is visible now
      assign raw_busy[gi] = busy_vec[gi] && !(ret_mask[gi] && (cnt_q[gi] == CNT_ONE));
`else
      assign raw_busy[gi] = busy_vec[gi];
`endif
      assign sat_vec[gi]  = wr_mask[gi] && (cnt_q[gi] == CNT_MAX);
      assign udf_vec[gi]  = ret_mask[gi] && !busy_vec[gi];

      assign inc = issue_grant && wr_mask[gi];
      assign dec = ret_mask[gi] && busy_vec[gi];

      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        case ({inc, dec})
          2'b10:   cnt_d[gi] = cnt_q[gi] + CNT_ONE;
          2'b01:   cnt_d[gi] = cnt_q[gi] - CNT_ONE;
          default: cnt_d[gi] = cnt_q[gi];
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign raw_hazard = (src1_valid && raw_busy[src1_idx]) ||
                      (src2_valid && raw_busy[src2_idx]);
  assign sat_hazard = |sat_vec;
  assign all_idle   = ~|busy_vec;

  assign issue_grant   = issue_req && (state_q == RUN) && !flush && !raw_hazard && !sat_hazard;
  assign stall_out     = issue_req && !issue_grant;
  assign draining      = (state_q == DRAIN);
  assign err_underflow = err_q;

  // Leaving DRAIN waits one cycle after the counters are seen empty; a repeat flush holds DRAIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (flush) state_q <= DRAIN;
        DRAIN:   if (all_idle && !flush) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|udf_vec) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, RDX:RAX pair, saturation, flush drain, underflow, async reset.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_req;
  logic [3:0]  src1_idx, src2_idx, dst_idx, wb_idx;
  logic        src1_valid, src2_valid, dst_valid, dst_special_valid;
  logic        wb_valid, wb_special_valid, flush;
  logic        issue_grant, stall_out, draining, err_underflow;
  logic [15:0] busy_vec;

  int checks   = 0;
  int failures = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .issue_req(issue_req),
    .src1_idx(src1_idx), .src1_valid(src1_valid),
    .src2_idx(src2_idx), .src2_valid(src2_valid),
    .dst_idx(dst_idx), .dst_valid(dst_valid), .dst_special_valid(dst_special_valid),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_special_valid(wb_special_valid),
    .flush(flush), .issue_grant(issue_grant), .stall_out(stall_out),
    .busy_vec(busy_vec), .draining(draining), .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic idle();
    issue_req = 0; src1_idx = 0; src1_valid = 0; src2_idx = 0; src2_valid = 0;
    dst_idx = 0; dst_valid = 0; dst_special_valid = 0;
    wb_valid = 0; wb_idx = 0; wb_special_valid = 0; flush = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic drive_issue(input logic [3:0] s1, input logic s1v, input logic [3:0] d, input logic dv);
    issue_req = 1; src1_idx = s1; src1_valid = s1v; dst_idx = d; dst_valid = dv;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk); #1;
    check("rst_busy", busy_vec, 16'h0000);
    check("rst_draining", draining, 0);
    check("rst_err", err_underflow, 0);
    check("rst_stall", stall_out, 0);
    check("rst_grant", issue_grant, 0);
    nxt(); reset = 1'b0;

    // independent issue then busy mark on dst 5
    nxt(); drive_issue(4'd3, 1, 4'd5, 1); #1;
    check("t1_grant", issue_grant, 1);
    check("t1_stall", stall_out, 0);
    nxt(); #1;
    check("t1_busy", busy_vec, 16'h0020);

    // RAW on reg 5 until its writeback
    drive_issue(4'd5, 1, 4'd0, 0); #1;
    check("t2_stall_a", stall_out, 1);
    nxt(); drive_issue(4'd5, 1, 4'd0, 0); #1;
    check("t2_stall_b", stall_out, 1);
    nxt(); drive_issue(4'd5, 1, 4'd0, 0); wb_valid = 1; wb_idx = 4'd5; #1;
    check("t2_wb_cycle_grant", issue_grant, BYP);
    nxt(); drive_issue(4'd5, 1, 4'd0, 0); #1;
    check("t2_after_wb_grant", issue_grant, 1);
    nxt(); #1;
    check("t2_busy", busy_vec, 16'h0000);

    // RDX:RAX pair
    issue_req = 1; dst_special_valid = 1; #1;
    check("t3_grant", issue_grant, 1);
    nxt(); #1;
    check("t3_busy", busy_vec, 16'h0005);
    issue_req = 1; src2_valid = 1; src2_idx = 4'd2; #1;
    check("t3_src2_stall", stall_out, 1);
    nxt(); wb_special_valid = 1;
    nxt(); #1;
    check("t3_busy_clr", busy_vec, 16'h0000);

    // saturation on reg 7
    drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_g1", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_g2", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_g3", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_sat_stall", stall_out, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); wb_valid = 1; wb_idx = 4'd7; #1;
    check("t4_sat_wb_stall", stall_out, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_g4", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_sat_again", stall_out, 1);
    nxt(); wb_valid = 1; wb_idx = 4'd7;
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); wb_valid = 1; wb_idx = 4'd7; #1;
    check("t4_incdec_grant", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_g5", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd7, 1); #1;
    check("t4_sat_final", stall_out, 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); wb_valid = 1; wb_idx = 4'd7;
    end
    nxt(); #1;
    check("t4_busy_clr", busy_vec, 16'h0000);

    // flush drain with writes pending on regs 1 and 4
    drive_issue(4'd0, 0, 4'd1, 1); #1;
    check("t5_g1", issue_grant, 1);
    nxt(); drive_issue(4'd0, 0, 4'd4, 1); #1;
    check("t5_g4", issue_grant, 1);
    nxt(); #1;
    check("t5_busy", busy_vec, 16'h0012);
    flush = 1; drive_issue(4'd8, 1, 4'd0, 0); #1;
    check("t5_flush_nogrant", issue_grant, 0);
    nxt(); #1;
    check("t5_draining", draining, 1);
    drive_issue(4'd8, 1, 4'd0, 0); #1;
    check("t5_drain_nogrant", issue_grant, 0);
    nxt(); drive_issue(4'd8, 1, 4'd0, 0); wb_valid = 1; wb_idx = 4'd1; #1;
    check("t5_drain_wb1_nogrant", issue_grant, 0);
    nxt(); wb_valid = 1; wb_idx = 4'd4; #1;
    check("t5_drain_wb4", draining, 1);
    nxt(); #1;
    check("t5_empty_still_drain", draining, 1);
    check("t5_empty_busy", busy_vec, 16'h0000);
    nxt(); #1;
    check("t5_run", draining, 0);
    drive_issue(4'd8, 1, 4'd0, 0); #1;
    check("t5_resume_grant", issue_grant, 1);

    // flush with nothing pending: one DRAIN cycle
    nxt(); flush = 1;
    nxt(); #1;
    check("t5b_drain_once", draining, 1);
    nxt(); #1;
    check("t5b_run", draining, 0);

    // underflow on reg 9, busy_vec unaffected
    drive_issue(4'd0, 0, 4'd3, 1); #1;
    check("t6_g3", issue_grant, 1);
    nxt(); wb_valid = 1; wb_idx = 4'd9; #1;
    check("t6_err_pre", err_underflow, 0);
    nxt(); #1;
    check("t6_err_set", err_underflow, 1);
    check("t6_busy", busy_vec, 16'h0008);
    nxt(); #1;
    check("t6_err_sticky", err_underflow, 1);
    drive_issue(4'd6, 1, 4'd6, 1); #1;
    check("t6_src_eq_dst_grant", issue_grant, 1);
    nxt(); flush = 1;
    nxt(); #1;
    check("t6_drain", draining, 1);
    check("t6_busy2", busy_vec, 16'h0048);
    #2 reset = 1'b1; #1;
    check("t6_async_draining", draining, 0);
    check("t6_async_err", err_underflow, 0);
    check("t6_async_busy", busy_vec, 16'h0000);
    nxt(); reset = 1'b0;
    nxt(); #1;
    check("t6_post_rst_draining", draining, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
